fp_add_arbiter: RTL and testbench

- Shares one floating-point adder port (add_operand_a/b, add_start, add_result, add_result_ready) among NUM_REQ requesters.
- Requesters are the angle combination, angle normalization and term accumulator sub-blocks. This replaces the hard per-state operand muxing in the expression evaluator.
- Start pulses are latched into per-requester pending slots, served in round-robin order, one transaction in flight at a time.
- The result is returned with a one-cycle ready pulse to the owner only.

---
 rtl/fp_arb_pkg.sv | 17 +
 rtl/rr_pointer_select.sv | 27 ++
 rtl/fp_add_arbiter.sv | 179 +++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared types and defaults for the floating-point unit arbiters.
// Imported by the adder arbiter and its round-robin picker.
package fp_arb_pkg;

    localparam int unsigned DEFAULT_NUM_REQ        = 3;
    localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int unsigned GRANT_W                = $clog2(DEFAULT_NUM_REQ);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StRespond
    } arb_state_t;

endpackage

// File: rtl/rr_pointer_select.sv
// Combinational round-robin picker: first set bit of pending_i searching upward
// from last_grant_i + 1, wrapping modulo NUM_REQ.
module rr_pointer_select #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_valid_o
);

    always_comb begin
        grant_o     = last_grant_i;
        any_valid_o = 1'b0;
        // Walk offsets from far to near so the nearest hit is written last.
        for (int off = int'(NUM_REQ); off >= 1; off--) begin
            int idx;
            idx = (int'(last_grant_i) + off) % int'(NUM_REQ);
            if (pending_i[idx]) begin
                grant_o     = IDX_W'(idx);
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one floating-point adder among NUM_REQ requesters: start pulses are
// latched into pending slots and served round-robin, one transaction at a time.
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_start_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         req_result_o,
    output logic [NUM_REQ-1:0]            req_pending_o,
    output logic [DATA_WIDTH-1:0]         add_operand_a_o,
    output logic [DATA_WIDTH-1:0]         add_operand_b_o,
    output logic                          add_start_o,
    input  logic [DATA_WIDTH-1:0]         add_result_i,
    input  logic                          add_result_ready_i,
    output logic                          overflow_err_o,
    output logic                          timeout_err_o
);

    localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_t              state_q, state_d;
    logic [IdxW-1:0]         grant_q, grant_d;
    logic [IdxW-1:0]         last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]      pending_q, pending_d;
    logic [NUM_REQ-1:0]      pending_clr;
    logic [DATA_WIDTH-1:0]   slot_a_q [NUM_REQ];
    logic [DATA_WIDTH-1:0]   slot_b_q [NUM_REQ];
    logic [DATA_WIDTH-1:0]   slot_a_d [NUM_REQ];
    logic [DATA_WIDTH-1:0]   slot_b_d [NUM_REQ];
    logic [DATA_WIDTH-1:0]   add_a_q, add_a_d;
    logic [DATA_WIDTH-1:0]   add_b_q, add_b_d;
    logic                    add_start_q, add_start_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
    logic [DATA_WIDTH-1:0]   req_result_q, req_result_d;
    logic [TimerW-1:0]       timer_q, timer_d;
    logic                    overflow_q, overflow_d;
    logic                    timeout_q, timeout_d;
    logic [IdxW-1:0]         pick_idx;
    logic                    pick_valid;

    rr_pointer_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_rr_pointer_select (
        .pending_i    (pending_q),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_idx),
        .any_valid_o  (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pending_clr  = '0;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_start_d  = 1'b0;
        req_ready_d  = '0;
        req_result_d = req_result_q;
        timer_d      = timer_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                add_a_d     = slot_a_q[grant_q];
                add_b_d     = slot_b_q[grant_q];
                add_start_d = 1'b1;
                timer_d     = '0;
                state_d     = StWait;
            end
            StWait: begin
                if (add_result_ready_i) begin
                    req_result_d         = add_result_i;
                    req_ready_d[grant_q] = 1'b1;
                    pending_clr[grant_q] = 1'b1;
                    last_grant_d         = grant_q;
                    state_d              = StRespond;
                end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: owner still gets a ready pulse so it never stalls.
                    timeout_d            = 1'b1;
                    req_result_d         = '0;
                    req_ready_d[grant_q] = 1'b1;
                    pending_clr[grant_q] = 1'b1;
                    last_grant_d         = grant_q;
                    state_d              = StRespond;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Slot capture; a new start wins over a clear on the same edge.
    always_comb begin
        pending_d  = pending_q;
        slot_a_d   = slot_a_q;
        slot_b_d   = slot_b_q;
        overflow_d = overflow_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req_start_i[i] && (!pending_q[i] || pending_clr[i])) begin
                pending_d[i] = 1'b1;
                slot_a_d[i]  = req_operand_a_i[i*DATA_WIDTH +: DATA_WIDTH];
                slot_b_d[i]  = req_operand_b_i[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (req_start_i[i]) begin
                overflow_d = 1'b1;
            end else if (pending_clr[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= IdxW'(NUM_REQ - 1);
            pending_q    <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                slot_a_q[i] <= '0;
                slot_b_q[i] <= '0;
            end
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_start_q  <= 1'b0;
            req_ready_q  <= '0;
            req_result_q <= '0;
            timer_q      <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            slot_a_q     <= slot_a_d;
            slot_b_q     <= slot_b_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_start_q  <= add_start_d;
            req_ready_q  <= req_ready_d;
            req_result_q <= req_result_d;
            timer_q      <= timer_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign req_result_o    = req_result_q;
    assign req_pending_o   = pending_q;
    assign add_operand_a_o = add_a_q;
    assign add_operand_b_o = add_b_q;
    assign add_start_o     = add_start_q;
    assign overflow_err_o  = overflow_q;
    assign timeout_err_o   = timeout_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: table of single requests plus hand-written
// contention, fairness, overflow, timeout and reset sequences.
module tb_fp_add_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req_start = '0;
    logic [95:0] opa_bus = '0;
    logic [95:0] opb_bus = '0;
    logic [2:0]  req_ready;
    logic [31:0] req_result;
    logic [2:0]  req_pending;
    logic [31:0] add_operand_a;
    logic [31:0] add_operand_b;
    logic        add_start;
    logic [31:0] add_result = 32'hDEAD_BEEF;
    logic        add_result_ready = 1'b0;
    logic        overflow_err;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    fp_add_arbiter #(
        .NUM_REQ        (3),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock_i            (clock),
        .reset_i            (reset),
        .req_start_i        (req_start),
        .req_operand_a_i    (opa_bus),
        .req_operand_b_i    (opb_bus),
        .req_ready_o        (req_ready),
        .req_result_o       (req_result),
        .req_pending_o      (req_pending),
        .add_operand_a_o    (add_operand_a),
        .add_operand_b_o    (add_operand_b),
        .add_start_o        (add_start),
        .add_result_i       (add_result),
        .add_result_ready_i (add_result_ready),
        .overflow_err_o     (overflow_err),
        .timeout_err_o      (timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        int          lat;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [2:0] mask, input logic [31:0] a0,
                               input logic [31:0] a1, input logic [31:0] a2);
        opa_bus   = {a2, a1, a0};
        opb_bus   = {a2 ^ 32'h1, a1 ^ 32'h1, a0 ^ 32'h1};
        req_start = mask;
        tick();
        req_start = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Wait for the adder start, check operands, answer after lat cycles, check the
    // ready pulse. Returns in the ready cycle with the number of ticks waited.
    task automatic serve(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sum, input int lat, output int n);
        n = 0;
        while (!add_start && n < 200) begin
            tick();
            n++;
        end
        chk($sformatf("add_start seen req%0d", k), 64'(add_start), 64'd1);
        chk($sformatf("add_operand_a req%0d", k), 64'(add_operand_a), 64'(a));
        chk($sformatf("add_operand_b req%0d", k), 64'(add_operand_b), 64'(b));
        for (int j = 1; j < lat; j++) begin
            tick();
            if (j == 1) begin
                chk($sformatf("add_start one cycle req%0d", k), 64'(add_start), 64'd0);
                chk($sformatf("add_operand_a stable req%0d", k), 64'(add_operand_a), 64'(a));
            end
        end
        add_result       = sum;
        add_result_ready = 1'b1;
        tick();
        add_result_ready = 1'b0;
        add_result       = 32'hDEAD_BEEF;
        chk($sformatf("req_ready req%0d", k), 64'(req_ready), 64'(3'b001 << k));
        chk($sformatf("req_result req%0d", k), 64'(req_result), 64'(sum));
    endtask

    initial begin
        int          n;
        int          cnt;
        logic [2:0]  seen;
        logic [31:0] hold;

        vecs[0] = '{idx: 1, a: 32'h3F80_0000, b: 32'h4000_0000, sum: 32'h4040_0000, lat: 5};
        vecs[1] = '{idx: 0, a: 32'h4040_0000, b: 32'h3F80_0000, sum: 32'h4080_0000, lat: 1};
        vecs[2] = '{idx: 2, a: 32'hC000_0000, b: 32'h4000_0000, sum: 32'h0000_0000, lat: 3};

        #2;
        reset = 1'b1;
        #3;
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset req_result", 64'(req_result), 64'd0);
        chk("reset req_pending", 64'(req_pending), 64'd0);
        chk("reset add_operands", 64'({add_operand_a, add_operand_b}), 64'd0);
        chk("reset add_start", 64'(add_start), 64'd0);
        chk("reset errors", 64'({overflow_err, timeout_err}), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Uncontended single requests.
        for (int v = 0; v < 3; v++) begin
            opa_bus = '0;
            opb_bus = '0;
            opa_bus[vecs[v].idx*32 +: 32] = vecs[v].a;
            opb_bus[vecs[v].idx*32 +: 32] = vecs[v].b;
            req_start = 3'b001 << vecs[v].idx;
            tick();
            req_start = '0;
            chk($sformatf("vec%0d pending", v), 64'(req_pending), 64'(3'b001 << vecs[v].idx));
            serve(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].sum, vecs[v].lat, n);
            chk($sformatf("vec%0d start latency", v), 64'(n), 64'd2);
            hold = req_result;
            tick();
            chk($sformatf("vec%0d ready drop", v), 64'(req_ready), 64'd0);
            chk($sformatf("vec%0d pending clear", v), 64'(req_pending), 64'd0);
            chk($sformatf("vec%0d result hold", v), 64'(req_result), 64'(vecs[v].sum));
            tick();
        end

        // Simultaneous starts right after reset: served 0,1,2.
        do_reset();
        pulse_start(3'b111, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000);
        chk("sim pending", 64'(req_pending), 64'd7);
        serve(0, 32'h1111_0000, 32'h1111_0001, 32'hA000_0000, 2, n);
        serve(1, 32'h2222_0000, 32'h2222_0001, 32'hA000_0001, 1, n);
        serve(2, 32'h3333_0000, 32'h3333_0001, 32'hA000_0002, 4, n);
        tick();
        chk("sim pending clear", 64'(req_pending), 64'd0);

        // Fairness: requester 0 re-queues on its own ready cycle.
        do_reset();
        pulse_start(3'b111, 32'h1000_0001, 32'h2000_0001, 32'h3000_0001);
        serve(0, 32'h1000_0001, 32'h1000_0000, 32'hB000_0000, 1, n);
        pulse_start(3'b001, 32'h1000_0002, 32'h0, 32'h0);
        serve(1, 32'h2000_0001, 32'h2000_0000, 32'hB000_0001, 1, n);
        serve(2, 32'h3000_0001, 32'h3000_0000, 32'hB000_0002, 1, n);
        serve(0, 32'h1000_0002, 32'h1000_0003, 32'hB000_0003, 1, n);
        chk("fair no overflow", 64'(overflow_err), 64'd0);
        tick();

        // Double start on slot 2 while pending.
        do_reset();
        pulse_start(3'b100, 32'h0, 32'h0, 32'h4444_0000);
        pulse_start(3'b100, 32'h0, 32'h0, 32'h5555_0000);
        chk("overflow_err set", 64'(overflow_err), 64'd1);
        serve(2, 32'h4444_0000, 32'h4444_0001, 32'hC000_0000, 2, n);
        seen = '0;
        cnt  = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            seen = seen | req_ready;
            cnt  = cnt + int'(add_start);
        end
        chk("overflow single ready", 64'(seen), 64'd0);
        chk("overflow single issue", 64'(cnt), 64'd0);
        chk("overflow sticky", 64'(overflow_err), 64'd1);

        // Adder never answers for requester 0; requester 1 is then issued.
        do_reset();
        pulse_start(3'b100, 32'h0, 32'h0, 32'h6666_0000);
        serve(2, 32'h6666_0000, 32'h6666_0001, 32'hD000_0000, 1, n);
        tick();
        pulse_start(3'b011, 32'h7777_0000, 32'h8888_0000, 32'h0);
        n = 0;
        while (!add_start && n < 20) begin
            tick();
            n++;
        end
        chk("timeout add_start", 64'(add_start), 64'd1);
        chk("timeout operand_a", 64'(add_operand_a), 64'h7777_0000);
        n = 0;
        while (req_ready == '0 && n < 200) begin
            tick();
            n++;
        end
        chk("timeout cycles", 64'(n), 64'd64);
        chk("timeout req_ready", 64'(req_ready), 64'd1);
        chk("timeout req_result", 64'(req_result), 64'd0);
        chk("timeout_err set", 64'(timeout_err), 64'd1);
        serve(1, 32'h8888_0000, 32'h8888_0001, 32'hE000_0000, 2, n);
        chk("timeout sticky", 64'(timeout_err), 64'd1);
        tick();

        // Reset asserted in the wait state, then a late adder answer.
        pulse_start(3'b010, 32'h0, 32'h9999_0000, 32'h0);
        n = 0;
        while (!add_start && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("midreset req_result", 64'(req_result), 64'd0);
        chk("midreset pending", 64'(req_pending), 64'd0);
        chk("midreset add_operands", 64'({add_operand_a, add_operand_b}), 64'd0);
        chk("midreset errors", 64'({overflow_err, timeout_err, add_start}), 64'd0);
        tick();
        reset = 1'b0;
        add_result       = 32'h1234_5678;
        add_result_ready = 1'b1;
        tick();
        add_result_ready = 1'b0;
        seen = '0;
        for (int j = 0; j < 4; j++) begin
            seen = seen | req_ready;
            tick();
        end
        chk("late ready ignored", 64'(seen), 64'd0);
        chk("late result ignored", 64'(req_result), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
